// File: rtl/mem_arbiter_pkg.sv
// Shared configuration for the memory arbiter: request kinds, FSM states,
// grant bit positions and the default starvation limit.
package mem_arbiter_pkg;

    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        KIND_LINE_RD = 2'd0,
        KIND_LINE_WR = 2'd1,
        KIND_BYTE_RD = 2'd2,
        KIND_BYTE_WR = 2'd3
    } mem_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Bit positions inside the one-hot grant vector
    localparam int GNT_IC = 0;
    localparam int GNT_DC = 1;
    localparam int GNT_IO = 2;

    function automatic logic kind_is_read(input mem_kind_e kind);
        return (kind == KIND_LINE_RD) || (kind == KIND_BYTE_RD);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: starved cache first, then IO, then the
// caches round-robin (favouring the cache not served last).
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       ic_valid,
    input  logic       dc_valid,
    input  logic       io_valid,
    input  logic       ic_starved,
    input  logic       dc_starved,
    input  logic       last_dc,
    output logic [2:0] grant
);

    logic ic_hot;
    logic dc_hot;

    // A starve flag only matters while its cache is still asking
    assign ic_hot = ic_valid && ic_starved;
    assign dc_hot = dc_valid && dc_starved;

    always_comb begin
        grant = 3'b000;
        if (ic_hot && dc_hot) begin
            grant[last_dc ? GNT_IC : GNT_DC] = 1'b1;
        end else if (ic_hot) begin
            grant[GNT_IC] = 1'b1;
        end else if (dc_hot) begin
            grant[GNT_DC] = 1'b1;
        end else if (io_valid) begin
            grant[GNT_IO] = 1'b1;
        end else if (ic_valid && dc_valid) begin
            grant[last_dc ? GNT_IC : GNT_DC] = 1'b1;
        end else if (ic_valid) begin
            grant[GNT_IC] = 1'b1;
        end else if (dc_valid) begin
            grant[GNT_DC] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-requester arbiter (icache, dcache, byte IO) in front of a single
// memory-controller port; one outstanding transaction at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int LINE_WIDTH   = 128,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  ic_valid,
    input  logic [ADDR_WIDTH-1:0] ic_addr,
    output logic                  ic_ready,
    output logic [LINE_WIDTH-1:0] ic_rdata,
    input  logic                  dc_valid,
    input  logic                  dc_rw,
    input  logic [ADDR_WIDTH-1:0] dc_addr,
    input  logic [LINE_WIDTH-1:0] dc_wdata,
    output logic                  dc_ready,
    output logic [LINE_WIDTH-1:0] dc_rdata,
    input  logic                  io_valid,
    input  logic                  io_rw,
    input  logic [ADDR_WIDTH-1:0] io_addr,
    input  logic [7:0]            io_wdata,
    output logic                  io_ready,
    output logic [7:0]            io_rdata,
    output logic                  mem_valid,
    output logic [1:0]            mem_kind,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [LINE_WIDTH-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e            state_q,     state_d;
    logic                  mem_valid_q, mem_valid_d;
    mem_kind_e             mem_kind_q,  mem_kind_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]            winner_q,    winner_d;
    logic                  ic_ready_q,  ic_ready_d;
    logic                  dc_ready_q,  dc_ready_d;
    logic                  io_ready_q,  io_ready_d;
    logic [LINE_WIDTH-1:0] ic_rdata_q,  ic_rdata_d;
    logic [LINE_WIDTH-1:0] dc_rdata_q,  dc_rdata_d;
    logic [7:0]            io_rdata_q,  io_rdata_d;
    logic [CNT_W-1:0]      ic_cnt_q,    ic_cnt_d;
    logic [CNT_W-1:0]      dc_cnt_q,    dc_cnt_d;
    logic                  last_dc_q,   last_dc_d;
    logic [2:0]            grant;

    arb_pick u_arb_pick (
        .ic_valid   (ic_valid),
        .dc_valid   (dc_valid),
        .io_valid   (io_valid),
        .ic_starved (ic_cnt_q == CNT_MAX),
        .dc_starved (dc_cnt_q == CNT_MAX),
        .last_dc    (last_dc_q),
        .grant      (grant)
    );

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_kind_d  = mem_kind_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        winner_d    = winner_q;
        ic_ready_d  = ic_ready_q;
        dc_ready_d  = dc_ready_q;
        io_ready_d  = io_ready_q;
        ic_rdata_d  = ic_rdata_q;
        dc_rdata_d  = dc_rdata_q;
        io_rdata_d  = io_rdata_q;
        ic_cnt_d    = ic_cnt_q;
        dc_cnt_d    = dc_cnt_q;
        last_dc_d   = last_dc_q;

        // rdy low leaves every *_d equal to its *_q, freezing the block
        if (rdy) begin
            case (state_q)
                ST_IDLE: begin
                    if (|grant) begin
                        mem_valid_d = 1'b1;
                        winner_d    = grant;
                        state_d     = ST_WAIT;
                        if (grant[GNT_IC]) begin
                            mem_kind_d  = KIND_LINE_RD;
                            mem_addr_d  = ic_addr;
                            mem_wdata_d = '0;
                            ic_cnt_d    = '0;
                            last_dc_d   = 1'b0;
                        end else if (grant[GNT_DC]) begin
                            mem_kind_d  = dc_rw ? KIND_LINE_WR : KIND_LINE_RD;
                            mem_addr_d  = dc_addr;
                            mem_wdata_d = dc_wdata;
                            dc_cnt_d    = '0;
                            last_dc_d   = 1'b1;
                        end else begin
                            mem_kind_d  = io_rw ? KIND_BYTE_WR : KIND_BYTE_RD;
                            mem_addr_d  = io_addr;
                            mem_wdata_d = LINE_WIDTH'(io_wdata);
                            if (ic_valid && ic_cnt_q != CNT_MAX) begin
                                ic_cnt_d = ic_cnt_q + CNT_W'(1);
                            end
                            if (dc_valid && dc_cnt_q != CNT_MAX) begin
                                dc_cnt_d = dc_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        mem_valid_d = 1'b0;
                        state_d     = ST_RESP;
                        ic_ready_d  = winner_q[GNT_IC];
                        dc_ready_d  = winner_q[GNT_DC];
                        io_ready_d  = winner_q[GNT_IO];
                        // Writes return nothing, so the requester's rdata is left alone
                        if (kind_is_read(mem_kind_q)) begin
                            if (winner_q[GNT_IC]) ic_rdata_d = mem_rdata;
                            if (winner_q[GNT_DC]) dc_rdata_d = mem_rdata;
                            if (winner_q[GNT_IO]) io_rdata_d = mem_rdata[7:0];
                        end
                    end
                end
                ST_RESP: begin
                    ic_ready_d = 1'b0;
                    dc_ready_d = 1'b0;
                    io_ready_d = 1'b0;
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mem_valid_q <= 1'b0;
            mem_kind_q  <= KIND_LINE_RD;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            winner_q    <= '0;
            ic_ready_q  <= 1'b0;
            dc_ready_q  <= 1'b0;
            io_ready_q  <= 1'b0;
            ic_rdata_q  <= '0;
            dc_rdata_q  <= '0;
            io_rdata_q  <= '0;
            ic_cnt_q    <= '0;
            dc_cnt_q    <= '0;
            last_dc_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_kind_q  <= mem_kind_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            winner_q    <= winner_d;
            ic_ready_q  <= ic_ready_d;
            dc_ready_q  <= dc_ready_d;
            io_ready_q  <= io_ready_d;
            ic_rdata_q  <= ic_rdata_d;
            dc_rdata_q  <= dc_rdata_d;
            io_rdata_q  <= io_rdata_d;
            ic_cnt_q    <= ic_cnt_d;
            dc_cnt_q    <= dc_cnt_d;
            last_dc_q   <= last_dc_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_kind  = mem_kind_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ic_ready  = ic_ready_q;
    assign dc_ready  = dc_ready_q;
    assign io_ready  = io_ready_q;
    assign ic_rdata  = ic_rdata_q;
    assign dc_rdata  = dc_rdata_q;
    assign io_rdata  = io_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of all address ports.
REQ-002 SHALL have parameter LINE_WIDTH, default 128: cache-line data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4: number of consecutive IO wins tolerated while a cache waits.
REQ-004 SHALL have port clk  in  1: single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port rdy  in  1: global enable; low freezes all state and outputs.
REQ-007 SHALL have ports ic_valid in 1, ic_addr in ADDR_WIDTH, ic_ready out 1, ic_rdata out LINE_WIDTH: icache line-read requester.
REQ-008 SHALL have ports dc_valid in 1, dc_rw in 1 (1=write), dc_addr in ADDR_WIDTH, dc_wdata in LINE_WIDTH, dc_ready out 1, dc_rdata out LINE_WIDTH: dcache line requester.
REQ-009 SHALL have ports io_valid in 1, io_rw in 1, io_addr in ADDR_WIDTH, io_wdata in 8, io_ready out 1, io_rdata out 8: byte IO requester.
REQ-010 SHALL have ports mem_valid out 1, mem_kind out 2 (0 line read, 1 line write, 2 byte read, 3 byte write), mem_addr out ADDR_WIDTH, mem_wdata out LINE_WIDTH (byte writes in bits 7:0), mem_ready in 1 (one-cycle completion pulse), mem_rdata in LINE_WIDTH: single downstream port to the memory controller.

Function
REQ-011 SHALL implement states IDLE, WAIT, RESP.
REQ-012 IDLE: on an edge with any valid high, SHALL latch winner's kind/addr/wdata into output registers, set mem_valid=1, go WAIT; no valid -> stay IDLE.
REQ-013 Priority SHALL be: starved cache (starve count == STARVE_LIMIT) > IO > caches round-robin.
REQ-014 Round-robin SHALL favour the cache not served last; both valid with last=icache -> dcache wins; last pointer resets to dcache (icache wins first tie).
REQ-015 Each cache starve counter SHALL increment (saturating at STARVE_LIMIT) when IO wins while that cache is valid, and clear when that cache wins.
REQ-016 Both caches starved simultaneously SHALL resolve by round-robin.
REQ-017 WAIT: mem_valid, mem_kind, mem_addr, mem_wdata SHALL hold stable until mem_ready sampled high.
REQ-018 On mem_ready in WAIT SHALL clear mem_valid, register mem_rdata (full line or bits 7:0) into winner's rdata, pulse winner's ready for exactly one cycle, go RESP.
REQ-019 RESP SHALL last one cycle, accept no request, then return to IDLE (requester drops valid in that cycle).
REQ-020 Latency SHALL be: request sampled at edge N -> mem_valid visible after N; mem_ready at edge M -> ready/rdata visible after M; minimum back-to-back spacing 3 cycles.
REQ-021 mem_ready outside WAIT SHALL be ignored.
REQ-022 Requester dropping valid during WAIT SHALL be ignored; transaction completes and ready still pulses.
REQ-023 rdata outputs SHALL hold last value until overwritten by a later response to the same requester.
REQ-024 rdy low SHALL freeze state, counters, pointer and all outputs, including a pending mem_ready sample (mem_ready ignored while rdy low).

Reset
REQ-025 rst low SHALL immediately force state IDLE, mem_valid=0, mem_kind=0, mem_addr=0, mem_wdata=0, all ready=0, all rdata=0, starve counters=0, pointer=dcache.
REQ-026 Reset mid-transaction SHALL abandon it without issuing any ready pulse.

Structure
REQ-027 mem_kind encodings, state encodings and STARVE_LIMIT default SHALL live in the shared config package.
REQ-028 Winner selection SHALL be one combinational sub-module, arb_pick (inputs: valids, starve flags, last pointer; output: one-hot grant).

Verification
REQ-029 Lone ic_valid, addr 0x1000; mem_ready 4 cycles later with rdata 0xA5..A5 -> mem_kind=0, mem_addr=0x1000, ic_ready one cycle, ic_rdata=0xA5..A5.
REQ-030 ic_valid and dc_valid together, held -> grants alternate icache, dcache, icache.
REQ-031 io_valid held continuously with dc_valid -> IO wins 4 times, dcache wins 5th grant, counter clears.
REQ-032 dc_rw=1 write 0x2000, wdata 0x0123..EF -> mem_kind=1, wdata stable all WAIT cycles, dc_ready one pulse, dc_rdata unchanged.
REQ-033 rst low during WAIT, then high with no valids -> mem_valid=0 at once, no ready pulse, IDLE.
REQ-034 rdy low for 3 cycles spanning mem_ready -> outputs frozen, mem_ready ignored; response completes only on a mem_ready sampled with rdy high.
